// File: rtl/arbiter_4x2_rr.sv
// Four-requester round-robin arbiter with a per-grant hold limit and a one-cycle gap between owners.
// Optional ARB_LOCK_EN macro adds a lock input that suspends the hold limit while asserted.
module arbiter_4x2_rr #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       hold_exp
);

  // state | meaning
  // IDLE  | no owner, arbitrate on every edge
  // BUSY  | gnt held by gnt_idx, hold_cnt counting
  // GAP   | one dead cycle after a release, then arbitrate
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] hold_cnt;
  logic [1:0] pick;
  logic       pick_vld;
  logic       owner_req;
  logic       limit_hit;
  logic       lock_act;

`ifdef ARB_LOCK_EN
  assign lock_act = lock;
`else
  assign lock_act = 1'b0;
`endif

  assign owner_req = req[gnt_idx];
  assign limit_hit = (hold_cnt == HOLD_LAST) && !lock_act;

  // Descending loop so the nearest set bit at or after ptr wins.
  always_comb begin
    pick     = ptr;
    pick_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        pick     = ptr + 2'(k);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      hold_cnt <= 8'd0;
      gnt      <= 4'b0000;
      gnt_idx  <= 2'd0;
      gnt_vld  <= 1'b0;
      hold_exp <= 1'b0;
    end else begin
      case (state)
        IDLE, GAP: begin
          hold_exp <= 1'b0;
          hold_cnt <= 8'd0;
          if (pick_vld) begin
            state   <= BUSY;
            gnt     <= 4'b0001 << pick;
            gnt_idx <= pick;
            gnt_vld <= 1'b1;
          end else begin
            state   <= IDLE;
            gnt     <= 4'b0000;
            gnt_idx <= 2'd0;
            gnt_vld <= 1'b0;
          end
        end
        BUSY: begin
          if (!owner_req || limit_hit) begin
            state    <= GAP;
            ptr      <= gnt_idx + 2'd1;
            hold_cnt <= 8'd0;
            gnt      <= 4'b0000;
            gnt_idx  <= 2'd0;
            gnt_vld  <= 1'b0;
            // A limit release with the request still up is the only forced release.
            hold_exp <= owner_req;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          gnt      <= 4'b0000;
          gnt_idx  <= 2'd0;
          gnt_vld  <= 1'b0;
          hold_exp <= 1'b0;
        end
      endcase
    end
  end

endmodule
